// File: rtl/resp_packer.sv
// Response framer: passes echo bytes through unchanged and wraps each result word in a
// header+payload packet, all on one valid/ready byte stream toward the UART transmitter.
module resp_packer #(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        echo_data_i,
    input  logic              echo_valid_i,
    output logic              echo_ready_o,
    input  logic [WORD_W-1:0] word_i,
    input  logic [7:0]        opcode_i,
    input  logic              word_valid_i,
    output logic              word_ready_o,
    output logic [7:0]        data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o
);

    localparam int unsigned NB      = WORD_W / 8;
    localparam int unsigned PKT_LEN = 4 + NB;
    localparam int unsigned IdxW    = $clog2(PKT_LEN);
    localparam logic [15:0] PktLen16 = 16'(PKT_LEN);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(PKT_LEN - 1);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StSendEcho = 2'd1;
    localparam logic [1:0] StSendWord = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [7:0]        byte_q, byte_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [7:0]        op_q, op_d;
    logic [IdxW-1:0]   idx_q, idx_d;

    logic       echo_ready;
    logic       word_ready;
    logic       valid;
    logic [7:0] data;
    logic [7:0] word_byte;
    logic       echo_acc;
    logic       word_acc;

    // Payload byte for the current index, least-significant byte first.
    always_comb begin
        word_byte = 8'h00;
        for (int i = 0; i < int'(NB); i++) begin
            if (idx_q == IdxW'(4 + i)) begin
                word_byte = word_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        echo_ready = 1'b0;
        word_ready = 1'b0;
        valid      = 1'b0;
        data       = 8'h00;
        unique case (state_q)
            StIdle: begin
                word_ready = 1'b1;
                echo_ready = !word_valid_i;
            end
            StSendEcho: begin
                valid      = 1'b1;
                data       = byte_q;
                echo_ready = ready_i && !word_valid_i;
            end
            StSendWord: begin
                valid = 1'b1;
                unique case (idx_q)
                    IdxW'(0): data = op_q;
                    IdxW'(1): data = 8'h00;
                    IdxW'(2): data = PktLen16[7:0];
                    IdxW'(3): data = PktLen16[15:8];
                    default:  data = word_byte;
                endcase
            end
            default: begin
                valid = 1'b0;
            end
        endcase
    end

    assign echo_acc = echo_valid_i && echo_ready;
    assign word_acc = word_valid_i && word_ready;

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        word_d  = word_q;
        op_d    = op_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (word_acc) begin
                    word_d  = word_i;
                    op_d    = opcode_i;
                    idx_d   = '0;
                    state_d = StSendWord;
                end else if (echo_acc) begin
                    byte_d  = echo_data_i;
                    state_d = StSendEcho;
                end
            end
            StSendEcho: begin
                if (ready_i) begin
                    if (echo_acc) begin
                        byte_d = echo_data_i;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StSendWord: begin
                if (ready_i) begin
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            byte_q  <= 8'h00;
            word_q  <= '0;
            op_q    <= 8'h00;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
        end
    end

    // Readies are forced low during reset so nothing is consumed while held.
    assign echo_ready_o = rst && echo_ready;
    assign word_ready_o = rst && word_ready;
    assign valid_o      = rst && valid;
    assign data_o       = rst ? data : 8'h00;
    assign busy_o       = rst && (state_q != StIdle);

endmodule

// File: tb/tb_resp_packer.sv
// Scoreboard bench for resp_packer: stimulus pushes expected bytes, a negedge monitor pops
// and compares on every output handshake.
module tb_resp_packer;

    logic        clk;
    logic        rst;
    logic [7:0]  echo_data_i;
    logic        echo_valid_i;
    logic        echo_ready_o;
    logic [31:0] word_i;
    logic [7:0]  opcode_i;
    logic        word_valid_i;
    logic        word_ready_o;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    logic       stall_pend = 1'b0;
    logic [7:0] stall_data = 8'h00;

    resp_packer #(
        .WORD_W(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .echo_data_i (echo_data_i),
        .echo_valid_i(echo_valid_i),
        .echo_ready_o(echo_ready_o),
        .word_i      (word_i),
        .opcode_i    (opcode_i),
        .word_valid_i(word_valid_i),
        .word_ready_o(word_ready_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: byte order/content via scoreboard, plus hold-stable under backpressure.
    always @(negedge clk) begin
        if (!rst) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                chk("stall_valid_hold", 32'(valid_o), 32'h1);
                chk("stall_data_hold", 32'(data_o), 32'(stall_data));
            end
            if (!valid_o) begin
                chk("idle_data_zero", 32'(data_o), 32'h0);
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 32'(data_o), 32'hFFFF_FFFF);
                end else begin
                    chk("stream_byte", 32'(data_o), 32'(exp_q.pop_front()));
                end
            end
            stall_pend = valid_o && !ready_i;
            stall_data = data_o;
        end
    end

    task automatic push_word(input logic [31:0] w, input logic [7:0] op);
        exp_q.push_back(op);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h00);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[31:24]);
    endtask

    // Waits (bounded) for the chosen ready at a negedge, then steps past the accepting edge.
    task automatic wait_accept(input bit is_word, output int waited);
        bit ok = 1'b0;
        waited = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            waited++;
            if (is_word ? word_ready_o : echo_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 32'(exp_q.size()), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int cnt;
        int stalls;
        logic [7:0] echo_bytes[3];
        logic [3:0] pat;

        echo_bytes[0] = 8'h41;
        echo_bytes[1] = 8'h42;
        echo_bytes[2] = 8'h43;
        pat = 4'b1001;

        // Reset with random inputs.
        rst          = 1'b0;
        echo_data_i  = 8'($urandom);
        echo_valid_i = 1'b1;
        word_i       = $urandom;
        opcode_i     = 8'($urandom);
        word_valid_i = 1'($urandom);
        ready_i      = 1'b1;
        #22;
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_data", 32'(data_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_word_ready", 32'(word_ready_o), 32'h0);
        chk("rst_echo_ready", 32'(echo_ready_o), 32'h0);
        echo_valid_i = 1'b0;
        word_valid_i = 1'b0;
        #8;
        rst = 1'b1;
        #1;
        chk("post_rst_word_ready", 32'(word_ready_o), 32'h1);
        chk("post_rst_echo_ready", 32'(echo_ready_o), 32'h1);
        @(posedge clk);
        #1;

        // Word packet at full rate.
        word_i       = 32'hDEADBEEF;
        opcode_i     = 8'h02;
        word_valid_i = 1'b1;
        push_word(32'hDEADBEEF, 8'h02);
        wait_accept(1'b1, w);
        word_valid_i = 1'b0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy_o) break;
            cnt++;
        end
        chk("word_busy_cycles", 32'(cnt), 32'd8);
        chk("word_ready_after_pkt", 32'(word_ready_o), 32'h1);
        chk("word_q_empty", 32'(exp_q.size()), 32'h0);
        @(posedge clk);
        #1;

        // Backpressure: ready pattern 1,0,0,1 repeating.
        word_valid_i = 1'b1;
        push_word(32'hDEADBEEF, 8'h02);
        wait_accept(1'b1, w);
        word_valid_i = 1'b0;
        cnt = 0;
        stalls = 0;
        for (int k = 0; k < 60; k++) begin
            ready_i = pat[3 - (k % 4)];
            @(negedge clk);
            if (!busy_o) break;
            cnt++;
            if (!ready_i) stalls++;
            @(posedge clk);
            #1;
        end
        ready_i = 1'b1;
        chk("bp_total_cycles", 32'(cnt), 32'd16);
        chk("bp_stalls", 32'(stalls), 32'd8);
        chk("bp_q_empty", 32'(exp_q.size()), 32'h0);
        @(posedge clk);
        #1;

        // Echo stream, back to back.
        for (int i = 0; i < 3; i++) begin
            echo_data_i  = echo_bytes[i];
            echo_valid_i = 1'b1;
            exp_q.push_back(echo_bytes[i]);
            wait_accept(1'b0, w);
            if (i > 0) chk("echo_b2b", 32'(w), 32'd1);
        end
        echo_valid_i = 1'b0;
        @(negedge clk);
        chk("echo_last_valid", 32'(valid_o), 32'h1);
        @(negedge clk);
        chk("echo_idle_after", 32'(busy_o), 32'h0);
        chk("echo_q_empty", 32'(exp_q.size()), 32'h0);
        @(posedge clk);
        #1;

        // Word and echo both valid in IDLE: word wins.
        word_i       = 32'h12345678;
        opcode_i     = 8'h05;
        word_valid_i = 1'b1;
        echo_data_i  = 8'h61;
        echo_valid_i = 1'b1;
        push_word(32'h12345678, 8'h05);
        exp_q.push_back(8'h61);
        @(negedge clk);
        chk("contend_echo_ready", 32'(echo_ready_o), 32'h0);
        chk("contend_word_ready", 32'(word_ready_o), 32'h1);
        @(posedge clk);
        #1;
        word_valid_i = 1'b0;
        wait_accept(1'b0, w);
        echo_valid_i = 1'b0;
        drain();

        // Word arrives mid echo stream.
        echo_data_i  = 8'h51;
        echo_valid_i = 1'b1;
        exp_q.push_back(8'h51);
        wait_accept(1'b0, w);
        echo_data_i = 8'h52;
        exp_q.push_back(8'h52);
        wait_accept(1'b0, w);
        echo_data_i  = 8'h53;
        word_i       = 32'h11223344;
        opcode_i     = 8'h07;
        word_valid_i = 1'b1;
        push_word(32'h11223344, 8'h07);
        exp_q.push_back(8'h53);
        @(negedge clk);
        chk("mid_echo_ready", 32'(echo_ready_o), 32'h0);
        chk("mid_echo_data", 32'(data_o), 32'h52);
        wait_accept(1'b1, w);
        word_valid_i = 1'b0;
        wait_accept(1'b0, w);
        echo_valid_i = 1'b0;
        drain();

        // Reset after three bytes of a packet.
        word_i       = 32'hCAFEF00D;
        opcode_i     = 8'h03;
        word_valid_i = 1'b1;
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h08);
        wait_accept(1'b1, w);
        word_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_valid", 32'(valid_o), 32'h1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid_o), 32'h0);
        chk("mid_rst_busy", 32'(busy_o), 32'h0);
        chk("mid_rst_q_empty", 32'(exp_q.size()), 32'h0);
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;
        word_i       = 32'h00000001;
        opcode_i     = 8'h01;
        word_valid_i = 1'b1;
        push_word(32'h00000001, 8'h01);
        wait_accept(1'b1, w);
        word_valid_i = 1'b0;
        drain();

        chk("final_q_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/resp_packer.md
# resp_packer

Response framer sitting directly downstream of the command FSM/ALU and upstream of the UART transmitter. It accepts raw echo bytes and 32-bit ALU result words. Echo bytes pass through unchanged. Each result word is wrapped in an 8-byte response packet in the same header format as incoming commands: opcode, reserved, length LSB, length MSB, then payload. Output is a single valid/ready byte stream to the TX side.

## Interface
- WORD_W, 32, result width in bits; multiple of 8. Payload bytes `NB = WORD_W/8`.
- `PKT_LEN`, derived `4 + NB` (8 by default), total response length in bytes including the header.
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- echo_data_i  input  8  echo byte from the FSM.
- echo_valid_i  input  1  echo byte present.
- echo_ready_o  output  1  echo byte accepted this cycle when high together with valid.
- word_i  input  WORD_W  ALU result.
- opcode_i  input  8  opcode of the command that produced `word_i`; sampled with `word_i`.
- word_valid_i  input  1  result present.
- word_ready_o  output  1  result accepted this cycle when high together with valid.
- data_o  output  8  byte to UART TX.
- valid_o  output  1  `data_o` is valid.
- ready_i  input  1  TX accepts `data_o`.
- busy_o  output  1  state is not IDLE.

## Operation
- **Registers:**
  - state: IDLE, SEND_ECHO or SEND_WORD.
  - `byte_q` [7:0].
  - `word_q` [WORD_W-1:0].
  - `op_q` [7:0].
  - `idx_q`: byte index, width `clog2(PKT_LEN)`.
- **IDLE:**
  - `word_ready_o = 1`; `echo_ready_o = !word_valid_i`.
  - If `word_valid_i` is high: capture `word_i` into `word_q` and `opcode_i` into `op_q`, clear `idx_q`, go to SEND_WORD.
  - Otherwise, if `echo_valid_i` is high: capture `echo_data_i` into `byte_q`, go to SEND_ECHO.
  - A word always has priority over an echo byte.
- **SEND_ECHO:**
  - `valid_o = 1`, `data_o = byte_q`, `word_ready_o = 0`.
  - `echo_ready_o = ready_i && !word_valid_i`.
  - On `ready_i` with an echo byte accepted: load the new byte into `byte_q` and stay in SEND_ECHO. This gives full throughput.
  - On `ready_i` with no echo byte accepted: go to IDLE.
  - Without `ready_i`: hold.
- **SEND_WORD:**
  - `valid_o = 1`; both input readies are 0.
  - `data_o` by `idx_q`:
    - 0: `op_q`
    - 1: `0x00`
    - 2: `PKT_LEN[7:0]`
    - 3: `PKT_LEN[15:8]`
    - 4 to PKT_LEN-1: `word_q` bytes, least-significant byte first.
  - On `ready_i`: `idx_q` increments. If `idx_q == PKT_LEN-1`, go to IDLE instead; `idx_q` never wraps inside a packet.
- **Output hold rules:**
  - While `valid_o` is high and `ready_i` is low, `data_o` and `valid_o` hold stable.
  - `valid_o` never drops without a handshake.
- When `valid_o = 0`, `data_o = 0x00`.
- `busy_o = (state != IDLE)`.

## Timing
- **Reset:**
  - While `rst` is low: state IDLE, all registers 0, and every output 0, including both readies (gated by `rst`).
  - First cycle after deassertion: `word_ready_o = 1`, and `echo_ready_o = 1` if no word is valid.
- **Word latency:** word accepted at edge N → byte 0 valid from cycle N+1. With `ready_i` held high, bytes occupy cycles N+1..N+8, state returns to IDLE at N+9, and the next word can be accepted at N+9. This is one idle-accept cycle per packet.
- **Echo latency:** byte accepted at N → output at N+1. Sustained echo gives 1 byte/cycle.
- **Backpressure:** each stalled cycle extends the packet by exactly one cycle; no bytes are dropped or duplicated.
- **Word arrives during SEND_ECHO:** the echo stream stops at the next handshake and the word is taken in the following IDLE cycle.
- **Reset mid-packet:** the packet is aborted and the remaining bytes are never emitted. `valid_o` falls asynchronously.

## Test plan
- **Reset values:** assert `rst = 0` with random inputs → `valid_o`, `data_o`, `busy_o` and both readies are 0. After release, `word_ready_o = 1` on the first cycle.
- **Word packet:** `word_i = 0xDEADBEEF`, `opcode_i = 0x02`, `ready_i = 1` → `data_o` = 02,00,08,00,EF,BE,AD,DE on 8 consecutive cycles. `busy_o` is high for exactly those 8 cycles; `word_ready_o` returns high at the 9th.
- **Backpressure:** same word with `ready_i` toggling 1,0,0,1,… → identical byte sequence; `data_o` stable on every stalled cycle; total cycles = 8 + number of stalls.
- **Echo stream:** bytes 0x41, 0x42, 0x43 back-to-back with `ready_i = 1` → output 0x41, 0x42, 0x43 on consecutive cycles with one cycle of latency. State returns to IDLE after 0x43.
- **Word/echo contention:**
  - `word_valid_i` and `echo_valid_i` both high in IDLE → `echo_ready_o = 0`; the full 8-byte word packet is emitted first, then the echo byte.
  - Word asserted mid-echo-stream → echo stops after the current byte and the word packet follows.
- **Reset mid-packet:** assert reset after 3 bytes of a word packet → `valid_o` drops immediately. After release, a new word (`0x00000001`, `opcode_i = 0x01`) gives 01,00,08,00,01,00,00,00 with no stale bytes.
